// File: rtl/player_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : player_pkg                                                    |
// | Purpose  : Shared types, arena constants and the tile-snap helper used   |
// |            by the player mover, the bomb manager and the sprite logic.   |
// | Contents : dir_t (facing encoding), move_state_t (mover FSM states),     |
// |            ARENA_* constants, snap_to_tile().                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package player_pkg;

  // Facing encoding as seen on the 'facing' output.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LIMIT = 2'd2
  } move_state_t;

  // Arena geometry in pixels (top-left corner limits of a sprite).
  localparam int ARENA_TILE_SIZE = 32;
  localparam int ARENA_OBJ_SIZE  = 32;
  localparam int ARENA_X_MIN     = 32;
  localparam int ARENA_X_MAX     = 448;
  localparam int ARENA_Y_MIN     = 32;
  localparam int ARENA_Y_MAX     = 416;

  // Tile containing the sprite centre, returned as that tile's top-left.
  // tile must be a power of two, so division/multiply reduce to a mask.
  function automatic logic signed [10:0] snap_to_tile(
    input logic signed [10:0] pos,
    input int                 half_obj,
    input int                 tile
  );
    logic signed [10:0] w_sum;
    w_sum = pos + 11'(half_obj);
    return w_sum & ~11'(tile - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_req_handshake.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bomb_req_handshake                                            |
// | Purpose  : Captures tile-snapped bomb coordinates on a placement request |
// |            and offers them to the bomb manager over valid/ready.         |
// | Ports    : clk, resetN (async, active-low)                               |
// |            i_place_bomb  - placement request (pulse or level)            |
// |            i_bomb_ready  - consumer accepts coordinates                  |
// |            i_pos_x/y     - current sprite top-left, pixels               |
// |            o_bomb_valid  - coordinates on o_bomb_x/y are valid           |
// |            o_bomb_x/y    - tile-aligned bomb coordinates                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bomb_req_handshake
  import player_pkg::*;
#(
  parameter int OBJ_SIZE  = ARENA_OBJ_SIZE,
  parameter int TILE_SIZE = ARENA_TILE_SIZE
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               i_place_bomb,
  input  logic               i_bomb_ready,
  input  logic signed [10:0] i_pos_x,
  input  logic signed [10:0] i_pos_y,
  output logic               o_bomb_valid,
  output logic signed [10:0] o_bomb_x,
  output logic signed [10:0] o_bomb_y
);

  logic               r_valid;
  logic signed [10:0] r_bomb_x;
  logic signed [10:0] r_bomb_y;

  // Coordinates only load while idle, so they stay frozen for the whole
  // time valid is high; requests during that window are dropped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_valid  <= 1'b0;
      r_bomb_x <= '0;
      r_bomb_y <= '0;
    end else if (!r_valid) begin
      if (i_place_bomb) begin
        r_valid  <= 1'b1;
        r_bomb_x <= snap_to_tile(i_pos_x, OBJ_SIZE / 2, TILE_SIZE);
        r_bomb_y <= snap_to_tile(i_pos_y, OBJ_SIZE / 2, TILE_SIZE);
      end
    end else if (i_bomb_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_bomb_valid = r_valid;
  assign o_bomb_x     = r_bomb_x;
  assign o_bomb_y     = r_bomb_y;

endmodule
`default_nettype wire

// File: rtl/player_grid_move.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : player_grid_move                                              |
// | Purpose  : Key-driven single-axis player mover with arena clamping,      |
// |            collision rollback and bomb-placement handshake.              |
// | Ports    : clk, resetN (async, active-low), startOfFrame (frame pulse),  |
// |            dir_keys [3]up [2]down [1]left [0]right, collision,           |
// |            place_bomb, bomb_ready, boost_pickup;                         |
// |            topLeftX/Y (pixels), facing, bomb_valid, bomb_x/y,            |
// |            boost_active.                                                 |
// | Options  : SPEED_BOOST_EN - boost_pickup doubles the step for            |
// |            BOOST_FRAMES frames; otherwise boost is tied off.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module player_grid_move
  import player_pkg::*;
#(
  parameter int INITIAL_X    = 256,
  parameter int INITIAL_Y    = 256,
  parameter int SPEED        = 128,
  parameter int FP_SHIFT     = 6,
  parameter int OBJ_SIZE     = ARENA_OBJ_SIZE,
  parameter int TILE_SIZE    = ARENA_TILE_SIZE,
  parameter int X_MIN        = ARENA_X_MIN,
  parameter int X_MAX        = ARENA_X_MAX,
  parameter int Y_MIN        = ARENA_Y_MIN,
  parameter int Y_MAX        = ARENA_Y_MAX,
  parameter int BOOST_FRAMES = 150
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [3:0]         dir_keys,
  input  logic               collision,
  input  logic               place_bomb,
  input  logic               bomb_ready,
  input  logic               boost_pickup,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         facing,
  output logic               bomb_valid,
  output logic signed [10:0] bomb_x,
  output logic signed [10:0] bomb_y,
  output logic               boost_active
);

  localparam logic signed [31:0] c_INIT_X_FP = 32'(INITIAL_X * (2 ** FP_SHIFT));
  localparam logic signed [31:0] c_INIT_Y_FP = 32'(INITIAL_Y * (2 ** FP_SHIFT));
  localparam logic signed [31:0] c_X_MIN_FP  = 32'(X_MIN * (2 ** FP_SHIFT));
  localparam logic signed [31:0] c_X_MAX_FP  = 32'(X_MAX * (2 ** FP_SHIFT));
  localparam logic signed [31:0] c_Y_MIN_FP  = 32'(Y_MIN * (2 ** FP_SHIFT));
  localparam logic signed [31:0] c_Y_MAX_FP  = 32'(Y_MAX * (2 ** FP_SHIFT));

  move_state_t        r_state,  w_state_nxt;
  logic signed [31:0] r_pos_x,  w_pos_x_nxt;
  logic signed [31:0] r_pos_y,  w_pos_y_nxt;
  logic signed [31:0] r_prev_x, w_prev_x_nxt;
  logic signed [31:0] r_prev_y, w_prev_y_nxt;
  dir_t               r_facing, w_facing_nxt;
  // Set once this frame's collision has been consumed.
  logic               r_rolled, w_rolled_nxt;

  logic               w_boost;
  logic signed [31:0] w_step;

  // ------------------------------------------------------------ boost
`ifdef SPEED_BOOST_EN
  logic [15:0] r_boost_cnt;

  // A pickup always (re)loads, even on a frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_boost_cnt <= '0;
    end else if (boost_pickup) begin
      r_boost_cnt <= 16'(BOOST_FRAMES);
    end else if (startOfFrame && (r_boost_cnt != 16'd0)) begin
      r_boost_cnt <= r_boost_cnt - 16'd1;
    end
  end

  assign w_boost = (r_boost_cnt != 16'd0);
`else
  logic w_unused_boost;
  assign w_unused_boost = boost_pickup ^ (BOOST_FRAMES != 0);
  assign w_boost        = 1'b0;
`endif

  assign w_step = w_boost ? 32'(2 * SPEED) : 32'(SPEED);

  // ------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_pos_x  <= c_INIT_X_FP;
      r_pos_y  <= c_INIT_Y_FP;
      r_prev_x <= c_INIT_X_FP;
      r_prev_y <= c_INIT_Y_FP;
      r_facing <= DOWN;
      r_rolled <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos_x  <= w_pos_x_nxt;
      r_pos_y  <= w_pos_y_nxt;
      r_prev_x <= w_prev_x_nxt;
      r_prev_y <= w_prev_y_nxt;
      r_facing <= w_facing_nxt;
      r_rolled <= w_rolled_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_x_nxt  = r_pos_x;
    w_pos_y_nxt  = r_pos_y;
    w_prev_x_nxt = r_prev_x;
    w_prev_y_nxt = r_prev_y;
    w_facing_nxt = r_facing;
    w_rolled_nxt = r_rolled;

    case (r_state)
      IDLE: begin
        if (startOfFrame) w_state_nxt = RUN;
      end

      RUN: begin
        if (startOfFrame && collision) begin
          // Rollback beats the step; this counts as the new frame's
          // one collision, so later collision cycles are ignored.
          w_pos_x_nxt  = r_prev_x;
          w_pos_y_nxt  = r_prev_y;
          w_rolled_nxt = 1'b1;
        end else if (startOfFrame) begin
          w_prev_x_nxt = r_pos_x;
          w_prev_y_nxt = r_pos_y;
          w_rolled_nxt = 1'b0;
          w_state_nxt  = LIMIT;
          if (dir_keys[3]) begin
            w_pos_y_nxt  = r_pos_y - w_step;
            w_facing_nxt = UP;
          end else if (dir_keys[2]) begin
            w_pos_y_nxt  = r_pos_y + w_step;
            w_facing_nxt = DOWN;
          end else if (dir_keys[1]) begin
            w_pos_x_nxt  = r_pos_x - w_step;
            w_facing_nxt = LEFT;
          end else if (dir_keys[0]) begin
            w_pos_x_nxt  = r_pos_x + w_step;
            w_facing_nxt = RIGHT;
          end
        end else if (collision && !r_rolled) begin
          w_pos_x_nxt  = r_prev_x;
          w_pos_y_nxt  = r_prev_y;
          w_rolled_nxt = 1'b1;
        end
      end

      LIMIT: begin
        if (r_pos_x < c_X_MIN_FP)      w_pos_x_nxt = c_X_MIN_FP;
        else if (r_pos_x > c_X_MAX_FP) w_pos_x_nxt = c_X_MAX_FP;
        if (r_pos_y < c_Y_MIN_FP)      w_pos_y_nxt = c_Y_MIN_FP;
        else if (r_pos_y > c_Y_MAX_FP) w_pos_y_nxt = c_Y_MAX_FP;
        w_state_nxt = RUN;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // Integer pixel part of the fixed-point position.
  assign topLeftX     = r_pos_x[FP_SHIFT +: 11];
  assign topLeftY     = r_pos_y[FP_SHIFT +: 11];
  assign facing       = r_facing;
  assign boost_active = w_boost;

  // ------------------------------------------------------------ bomb
  bomb_req_handshake #(
    .OBJ_SIZE  (OBJ_SIZE),
    .TILE_SIZE (TILE_SIZE)
  ) u_bomb_req (
    .clk          (clk),
    .resetN       (resetN),
    .i_place_bomb (place_bomb),
    .i_bomb_ready (bomb_ready),
    .i_pos_x      (topLeftX),
    .i_pos_y      (topLeftY),
    .o_bomb_valid (bomb_valid),
    .o_bomb_x     (bomb_x),
    .o_bomb_y     (bomb_y)
  );

endmodule
`default_nettype wire
